// File: rtl/rggen_trigger_handshake.sv
// Per-channel trigger-to-request handshake with a saturating pending counter.
// Optional sticky overflow flags are built when RGGEN_TRIGGER_HANDSHAKE_OVERFLOW_EN is defined.
module rggen_trigger_handshake #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned PENDING_WIDTH = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [WIDTH-1:0]               i_trigger,
  output logic [WIDTH-1:0]               o_request,
  input  logic [WIDTH-1:0]               i_acknowledge,
  output logic [WIDTH*PENDING_WIDTH-1:0] o_pending_count,
  output logic [WIDTH-1:0]               o_overflow,
  input  logic [WIDTH-1:0]               i_overflow_clear
);

  localparam logic [PENDING_WIDTH-1:0] CntMax = '1;
  localparam logic [PENDING_WIDTH-1:0] CntOne = PENDING_WIDTH'(1);

  logic [WIDTH-1:0]                    req_q, req_d;
  logic [WIDTH-1:0][PENDING_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]                    drop;

  always_comb begin
    req_d = req_q;
    cnt_d = cnt_q;
    drop  = '0;
    for (int n = 0; n < int'(WIDTH); n++) begin
      if (!req_q[n]) begin
        if (i_trigger[n]) req_d[n] = 1'b1;
      end else if (!i_acknowledge[n]) begin
        if (i_trigger[n]) begin
          if (cnt_q[n] != CntMax) cnt_d[n] = cnt_q[n] + CntOne;
          else                    drop[n]  = 1'b1;
        end
      end else if (!i_trigger[n]) begin
        // A transfer with a trigger in the same cycle leaves the state unchanged.
        if (cnt_q[n] != '0) cnt_d[n] = cnt_q[n] - CntOne;
        else                req_d[n] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      req_q <= '0;
      cnt_q <= '0;
    end else begin
      req_q <= req_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_request       = req_q;
  assign o_pending_count = cnt_q;

`ifdef RGGEN_TRIGGER_HANDSHAKE_OVERFLOW_EN
  logic [WIDTH-1:0] ovf_q, ovf_d;

  // Setting takes priority over a simultaneous clear.
  assign ovf_d = drop | (ovf_q & ~i_overflow_clear);

  always_ff @(posedge i_clk) begin
    if (i_rst) ovf_q <= '0;
    else       ovf_q <= ovf_d;
  end

  assign o_overflow = ovf_q;
`else
  logic unused_ovf;

  assign unused_ovf = ^{i_overflow_clear, drop};
  assign o_overflow = '0;
`endif

endmodule

// File: tb/tb_rggen_trigger_handshake.sv
// Scoreboard bench: stimulus pushes expected state from an event-count model,
// a monitor pops and compares once per cycle after the rising edge.
module tb_rggen_trigger_handshake;

  localparam int W   = 8;
  localparam int PW  = 2;
  localparam int Cap = 1 << PW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [W-1:0]    trig = '0, ack = '0, clr = '0;
  logic [W-1:0]    req, ovf;
  logic [W*PW-1:0] cnt;

  always #5 clk = ~clk;

  rggen_trigger_handshake #(
    .WIDTH         (W),
    .PENDING_WIDTH (PW)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_trigger        (trig),
    .o_request        (req),
    .i_acknowledge    (ack),
    .o_pending_count  (cnt),
    .o_overflow       (ovf),
    .i_overflow_clear (clr)
  );

  typedef struct packed {
    logic [W-1:0]    req;
    logic [W*PW-1:0] cnt;
    logic [W-1:0]    ovf;
  } exp_t;

  exp_t sb_q[$];
  int   outst[W];
  bit   ovf_m[W];
  int   passes = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Model: each channel holds a number of outstanding events (0..Cap).
  task automatic step(input logic [W-1:0] t, input logic [W-1:0] a,
                      input logic [W-1:0] c, input logic r);
    exp_t e;
    @(negedge clk);
    trig = t;
    ack  = a;
    clr  = c;
    rst  = r;
    for (int n = 0; n < W; n++) begin
      if (r) begin
        outst[n] = 0;
        ovf_m[n] = 1'b0;
      end else begin
        int  nxt;
        bit  dropped;
        dropped = 1'b0;
        nxt = outst[n];
        if (outst[n] > 0 && a[n]) nxt--;
        if (t[n]) begin
          if (nxt < Cap) nxt++;
          else           dropped = 1'b1;
        end
        outst[n] = nxt;
`ifdef RGGEN_TRIGGER_HANDSHAKE_OVERFLOW_EN
        if (dropped)   ovf_m[n] = 1'b1;
        else if (c[n]) ovf_m[n] = 1'b0;
`else
        ovf_m[n] = 1'b0;
`endif
      end
      e.req[n]           = (outst[n] > 0);
      e.cnt[n*PW +: PW]  = (outst[n] > 0) ? PW'(outst[n] - 1) : '0;
      e.ovf[n]           = ovf_m[n];
    end
    sb_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("request", 64'(req), 64'(e.req));
        check("pending_count", 64'(cnt), 64'(e.cnt));
        check("overflow", 64'(ovf), 64'(e.ovf));
      end
    end
  end

  initial begin : stimulus
    logic [W-1:0] dens;
    for (int n = 0; n < W; n++) begin
      outst[n] = 0;
      ovf_m[n] = 1'b0;
    end
    step('0, '0, '0, 1'b1);
    step('1, '1, '0, 1'b1);   // triggers during reset are ignored
    // Idle trigger, hold, single-cycle acknowledge.
    step(8'h01, '0, '0, 1'b0);
    step('0, '0, '0, 1'b0);
    step('0, '0, '0, 1'b0);
    step('0, 8'h01, '0, 1'b0);
    step('0, '0, '0, 1'b0);
    // Accumulate three pending on channel 2, then drain with ack held.
    repeat (4) step(8'h04, '0, '0, 1'b0);
    step('0, '0, '0, 1'b0);
    repeat (4) step('0, 8'h04, '0, 1'b0);
    step('0, '0, '0, 1'b0);
    // Saturate channel 0, drop one, clear, then set and clear together.
    repeat (4) step(8'h01, '0, '0, 1'b0);
    step(8'h01, '0, '0, 1'b0);
    step('0, '0, 8'h01, 1'b0);
    step(8'h01, '0, 8'h01, 1'b0);
    step('0, '0, '0, 1'b0);
    repeat (5) step('0, 8'h01, '0, 1'b0);
    // Trigger and transfer in the same cycle with one pending.
    repeat (2) step(8'h02, '0, '0, 1'b0);
    step(8'h02, 8'h02, '0, 1'b0);
    repeat (3) step('0, 8'h02, '0, 1'b0);
    // Reset mid-operation with count 2 on every channel.
    repeat (3) step('1, '0, '0, 1'b0);
    step('1, '1, '1, 1'b1);
    step('0, '0, '0, 1'b0);
    // Randomized phases with varying acknowledge density.
    dens = '0;
    for (int i = 0; i < 800; i++) begin
      if (i % 50 == 0) dens = W'($urandom);
      step(W'($urandom) & W'($urandom),
           W'($urandom) & dens & W'($urandom),
           W'($urandom) & W'($urandom) & W'($urandom),
           ($urandom_range(0, 299) == 0));
    end
    step('0, '0, '0, 1'b0);
    @(posedge clk);
    #3;
    total++;
    if (sb_q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
